// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: EX/MEM and MEM/WB bus layouts and the
// memory-access FSM encoding. The EX and WB stages import this package so that
// every stage agrees on field positions.
package mem_stage_pkg;

    localparam int XLEN     = 32;
    localparam int REG_W    = 5;
    localparam int EXMEM_W  = 141;
    localparam int MEMWB_W  = 71;

    // EX/MEM bus, MSB first. Bit positions:
    // [140:109] instr, [108] valid, [107] reserved, [106] branch,
    // [105] memtoreg, [104] regwrite, [103] memwrite, [102] memread,
    // [101] zero, [100:69] alu_result, [68:37] store_data, [36:32] rd,
    // [31:0] br_target
    typedef struct packed {
        logic [XLEN-1:0]  instr;
        logic             valid;
        logic             rsvd;
        logic             branch;
        logic             memtoreg;
        logic             regwrite;
        logic             memwrite;
        logic             memread;
        logic             zero;
        logic [XLEN-1:0]  alu_result;
        logic [XLEN-1:0]  store_data;
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  br_target;
    } exmem_t;

    // MEM/WB bus, MSB first. Bit positions:
    // [70] memtoreg, [69] regwrite, [68:64] rd, [63:32] alu_result,
    // [31:0] load_data
    typedef struct packed {
        logic             memtoreg;
        logic             regwrite;
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  alu_result;
        logic [XLEN-1:0]  load_data;
    } memwb_t;

    // Memory-access FSM: ACCESS issues requests, WAIT_RSP waits for load data
    typedef enum logic [0:0] {
        ST_ACCESS   = 1'b0,
        ST_WAIT_RSP = 1'b1
    } mem_state_e;

    // Word accesses must have the two low address bits clear
    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction in ex_q, drives the data-memory
// request/response handshake, stalls upstream while an access is pending and
// writes the MEM/WB register when the instruction retires.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter bit ALIGN_CHK = 1'b1
) (
    input  logic               CLK,
    input  logic               RSTN,
    input  logic [EXMEM_W-1:0] EXMEM,
    output logic               STALL,
    output logic               DM_REQ,
    output logic               DM_WE,
    output logic [XLEN-1:0]    DM_ADDR,
    output logic [XLEN-1:0]    DM_WDATA,
    input  logic               DM_GNT,
    input  logic               DM_RVALID,
    input  logic [XLEN-1:0]    DM_RDATA,
    output logic [MEMWB_W-1:0] MEMWB,
    output logic               MEMWB_VALID,
    output logic               PCSRC,
    output logic [XLEN-1:0]    BR_TARGET,
    output logic               ALIGN_ERR
);

    exmem_t     ex_q_r;
    mem_state_e state_r;
    mem_state_e state_next_s;
    memwb_t     memwb_r;
    logic       memwb_valid_r;
    logic       align_err_r;

    logic       misalign_s;
    logic       mem_op_s;
    logic       is_load_s;
    logic       stall_s;
    logic       retire_s;
    logic       dm_req_s;
    logic       pcsrc_s;
    logic       unused_s;

    // Instruction word and reserved bit travel through ex_q but are not used here
    assign unused_s = ^{ex_q_r.instr, ex_q_r.rsvd};

    // Decode the held instruction into access class and alignment status
    always_comb begin
        misalign_s = 1'b0;
        mem_op_s   = 1'b0;
        is_load_s  = 1'b0;
        misalign_s = ALIGN_CHK & ex_q_r.valid & (ex_q_r.memread | ex_q_r.memwrite)
                   & is_misaligned(ex_q_r.alu_result);
        mem_op_s   = ex_q_r.valid & (ex_q_r.memread | ex_q_r.memwrite) & ~misalign_s;
        // An op flagged as both read and write is issued as a store
        is_load_s  = ex_q_r.memread & ~ex_q_r.memwrite;
    end

    // Stage register: capture the upstream bus whenever we are not stalling
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            ex_q_r <= '0;
        end else if (!stall_s) begin
            ex_q_r <= exmem_t'(EXMEM);
        end else begin
            ex_q_r <= ex_q_r;
        end
    end

    // FSM state register
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_r <= ST_ACCESS;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state: a granted load waits for its data; GNT is ignored while waiting
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_ACCESS: begin
                if (mem_op_s && is_load_s && DM_GNT) begin
                    state_next_s = ST_WAIT_RSP;
                end else begin
                    state_next_s = ST_ACCESS;
                end
            end
            ST_WAIT_RSP: begin
                if (DM_RVALID || !mem_op_s) begin
                    state_next_s = ST_ACCESS;
                end else begin
                    state_next_s = ST_WAIT_RSP;
                end
            end
            default: state_next_s = ST_ACCESS;
        endcase
    end

    // FSM outputs: request, stall and retire qualification; RVALID only counts in WAIT_RSP
    always_comb begin
        dm_req_s = 1'b0;
        stall_s  = 1'b0;
        retire_s = 1'b0;
        pcsrc_s  = 1'b0;
        case (state_r)
            ST_ACCESS: begin
                dm_req_s = mem_op_s;
                stall_s  = mem_op_s & (~DM_GNT | is_load_s);
            end
            ST_WAIT_RSP: begin
                dm_req_s = 1'b0;
                stall_s  = mem_op_s & ~DM_RVALID;
            end
            default: begin
                dm_req_s = 1'b0;
                stall_s  = 1'b0;
            end
        endcase
        retire_s = ex_q_r.valid & ~stall_s;
        pcsrc_s  = ex_q_r.valid & ex_q_r.branch & ex_q_r.zero;
    end

    // MEM/WB register: written once per retired instruction, held otherwise
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            memwb_r       <= '0;
            memwb_valid_r <= 1'b0;
            align_err_r   <= 1'b0;
        end else if (retire_s) begin
            memwb_r.load_data  <= (mem_op_s && is_load_s) ? DM_RDATA : 32'h0000_0000;
            memwb_r.alu_result <= ex_q_r.alu_result;
            memwb_r.rd         <= ex_q_r.rd;
            memwb_r.regwrite   <= ex_q_r.regwrite & ~misalign_s;
            memwb_r.memtoreg   <= ex_q_r.memtoreg;
            memwb_valid_r      <= 1'b1;
            align_err_r        <= misalign_s;
        end else begin
            memwb_r       <= memwb_r;
            memwb_valid_r <= 1'b0;
            align_err_r   <= 1'b0;
        end
    end

    assign STALL       = stall_s;
    assign DM_REQ      = dm_req_s;
    assign DM_WE       = ex_q_r.memwrite;
    assign DM_ADDR     = ex_q_r.alu_result;
    assign DM_WDATA    = ex_q_r.store_data;
    assign MEMWB       = memwb_r;
    assign MEMWB_VALID = memwb_valid_r;
    assign PCSRC       = pcsrc_s;
    assign BR_TARGET   = ex_q_r.br_target;
    assign ALIGN_ERR   = align_err_r;

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter ALIGN_CHK, default 1: when 1, a load or store with ALU result bits [1:0] != 0 raises an alignment error and makes no memory access.
REQ-002 CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 RSTN  input  1  reset, asynchronous, active-low.
REQ-004 EXMEM  input  141  EX/MEM bus: [31:0] branch target, [36:32] dest reg, [68:37] store data, [100:69] ALU result, [101] zero/compare flag, [102] memread, [103] memwrite, [104] regwrite, [105] memtoreg, [106] branch, [107] reserved, [108] valid, [140:109] instruction.
REQ-005 STALL  output  1  high = upstream SHALL hold EXMEM unchanged.
REQ-006 DM_REQ  output  1  data-memory request.
REQ-007 DM_WE  output  1  1 = write, 0 = read; meaningful only while DM_REQ is high.
REQ-008 DM_ADDR  output  32  byte address, equal to the captured ALU result.
REQ-009 DM_WDATA  output  32  store data.
REQ-010 DM_GNT  input  1  request accepted in the cycle where DM_REQ and DM_GNT are both high.
REQ-011 DM_RVALID  input  1  read data valid.
REQ-012 DM_RDATA  input  32  read data.
REQ-013 MEMWB  output  71  MEM/WB bus: [31:0] load data, [63:32] ALU result, [68:64] dest reg, [69] regwrite, [70] memtoreg.
REQ-014 MEMWB_VALID  output  1  one-cycle pulse per retired instruction.
REQ-015 PCSRC  output  1  branch taken.
REQ-016 BR_TARGET  output  32  branch target address.
REQ-017 ALIGN_ERR  output  1  registered one-cycle pulse on an alignment error.

Function
REQ-018 Internal stage register ex_q SHALL load EXMEM on every CLK edge where STALL is low.
REQ-019 FSM states SHALL be ACCESS (default) and WAIT_RSP.
REQ-020 Memory op = ex_q valid & (memread | memwrite) & no alignment error.
REQ-021 DM_REQ = memory op & state ACCESS; DM_WE = memwrite; address and data come from ex_q; all combinational from ex_q and state.
REQ-022 Load in ACCESS: on DM_GNT go to WAIT_RSP; in WAIT_RSP on DM_RVALID go to ACCESS and register MEMWB[31:0] = DM_RDATA.
REQ-023 Store in ACCESS: completes in the DM_GNT cycle; FSM stays in ACCESS.
REQ-024 STALL = memory op & ((ACCESS & !DM_GNT) | (load & ACCESS) | (WAIT_RSP & !DM_RVALID)); a load therefore stalls until the RVALID cycle, and a store until the GNT cycle.
REQ-025 Non-memory instruction (valid, no memread/memwrite): retires at the next edge with latency 1 and MEMWB[31:0] = 0.
REQ-026 On retire, MEMWB SHALL be written with ALU result, dest reg, regwrite and memtoreg from ex_q, and MEMWB_VALID SHALL pulse high for 1 cycle.
REQ-027 When ex_q valid = 0, MEMWB SHALL hold its value and MEMWB_VALID SHALL be 0.
REQ-028 Alignment error: no request is made; the instruction retires at the next edge with regwrite forced to 0, and ALIGN_ERR pulses together with MEMWB_VALID.
REQ-029 PCSRC = ex_q valid & branch & zero flag, combinational; BR_TARGET = ex_q[31:0].
REQ-030 DM_RVALID sampled in ACCESS SHALL be ignored.
REQ-031 DM_GNT sampled in WAIT_RSP SHALL be ignored.
REQ-032 Back-to-back loads SHALL add no bubble beyond the memory wait cycles.

Reset
REQ-033 RSTN low SHALL asynchronously clear ex_q (valid = 0), set FSM = ACCESS, MEMWB = 0, MEMWB_VALID = 0, ALIGN_ERR = 0; DM_REQ, STALL and PCSRC therefore go low.
REQ-034 Reset during WAIT_RSP SHALL abandon the access; a late DM_RVALID after release SHALL have no effect.

Structure
REQ-035 A shared package SHALL hold the EXMEM/MEMWB field positions and widths and the FSM state encoding, for reuse by the EX and WB stages.
REQ-036 There SHALL be no sub-module: the FSM and stage register live in mem_stage.

Verification
REQ-037 ALU op: EXMEM valid, result 0x0000_0010, rd 5, regwrite 1 -> next edge MEMWB[63:32] = 0x10, [68:64] = 5, MEMWB_VALID 1-cycle pulse, STALL never high.
REQ-038 Load: address 0x100, GNT after 2 cycles, RVALID 3 cycles later with data 0xDEADBEEF -> DM_REQ/DM_WE=0/DM_ADDR=0x100 held until GNT; STALL high throughout; MEMWB[31:0] = 0xDEADBEEF on the RVALID edge.
REQ-039 Store: address 0x204, data 0x12345678, GNT in cycle 1 -> DM_WE = 1, DM_WDATA = 0x12345678, no stall cycle, MEMWB_VALID pulse with regwrite 0.
REQ-040 Misaligned load: address 0x102 -> DM_REQ stays low, ALIGN_ERR and MEMWB_VALID pulse at the next edge, MEMWB[69] = 0.
REQ-041 Branch: branch = 1, zero = 1, target 0x0040_0020 -> PCSRC = 1 and BR_TARGET = 0x0040_0020 while ex_q holds the instruction; with zero = 0, PCSRC = 0.
REQ-042 RSTN pulsed low in WAIT_RSP, then RVALID asserted -> all outputs 0, state ACCESS, no MEMWB_VALID pulse.
